// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
// Module : simon_pkg
// Brief  : Shared types, speed tables and LFSR constants for the Simon player.
// Rev    : 1.0  initial release
// ============================================================================
package simon_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        RED    = 2'd1,
        YELLOW = 2'd2,
        BLUE   = 2'd3
    } color_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GEN  = 3'd1,
        ST_ON   = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } player_state_t;

    // Indexed by the 2-bit speed code; values are in timing ticks.
    localparam logic [5:0] ON_TICKS  [4] = '{6'd60, 6'd40, 6'd25, 6'd15};
    localparam logic [5:0] GAP_TICKS [4] = '{6'd20, 6'd15, 6'd10, 6'd5};

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [3:0] color_onehot(input color_t c);
        return 4'b0001 << c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module : lfsr16
// Brief  : Free-running 16-bit Galois LFSR, right-shifting, never reaches zero.
// Rev    : 1.0  initial release
// ============================================================================
module lfsr16
    import simon_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [15:0] value
);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            value <= LFSR_SEED;
        end else begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sequence_player.sv
`default_nettype none
// ============================================================================
// Module : sequence_player
// Brief  : Generates a pseudo-random Simon sequence and plays it on four LEDs.
// Rev    : 1.0  initial release
// ============================================================================
module sequence_player
    import simon_pkg::*;
#(
    parameter int MAX_LEN  = 32,
    parameter int TICK_CYC = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [5:0] i_seq_len,
    input  logic [1:0] i_speed,
    input  logic       i_play,
    input  logic [5:0] i_round,
    input  logic [4:0] i_rd_idx,
    output logic [1:0] o_rd_color,
    output logic [3:0] o_led,
    output logic [5:0] o_seq_len,
    output logic       o_seq_valid,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam int            PRE_W     = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYC - 1);
    localparam logic [5:0]    MAX_LEN_6 = 6'(MAX_LEN);

    player_state_t    state, next_state;
    logic [15:0]      lfsr;
    logic             unused_lfsr;
    color_t           mem [MAX_LEN];
    logic [4:0]       gen_idx;
    logic [5:0]       seq_len, eff_len, round_r, step, phase_limit;
    logic [1:0]       speed_r, rd_color;
    logic [PRE_W-1:0] pre;
    logic [5:0]       ticks;
    logic             seq_valid, err, play_ok, phase_end, gen_last;

    lfsr16 u_lfsr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .value   (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:2];

    assign eff_len   = (i_seq_len == 6'd0 || i_seq_len > MAX_LEN_6) ? MAX_LEN_6 : i_seq_len;
    assign play_ok   = seq_valid && (i_round != 6'd0) && (i_round <= seq_len);
    assign gen_last  = ({1'b0, gen_idx} == seq_len - 6'd1);
    assign phase_limit = (state == ST_ON) ? ON_TICKS[speed_r] : GAP_TICKS[speed_r];
    assign phase_end = (pre == PRE_LAST) && (ticks == phase_limit - 6'd1);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (i_play && play_ok) next_state = ST_ON;
            ST_GEN:  if (gen_last)          next_state = ST_IDLE;
            ST_ON:   if (phase_end)         next_state = ST_GAP;
            ST_GAP:  if (phase_end)         next_state = (step == round_r - 6'd1) ? ST_DONE : ST_ON;
            ST_DONE:                        next_state = ST_IDLE;
            default:                        next_state = ST_IDLE;
        endcase
        // A start request overrides everything, including a same-cycle play.
        if (i_start) next_state = ST_GEN;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            gen_idx   <= 5'd0;
            seq_len   <= 6'd0;
            seq_valid <= 1'b0;
            step      <= 6'd0;
            round_r   <= 6'd0;
            speed_r   <= 2'd0;
            pre       <= '0;
            ticks     <= 6'd0;
            err       <= 1'b0;
            rd_color  <= 2'd0;
        end else begin
            state    <= next_state;
            err      <= 1'b0;
            rd_color <= mem[i_rd_idx];
            // Phase timers restart whenever the state changes.
            if (next_state != state) begin
                pre   <= '0;
                ticks <= 6'd0;
            end else if (pre == PRE_LAST) begin
                pre   <= '0;
                ticks <= ticks + 6'd1;
            end else begin
                pre <= pre + 1'b1;
            end
            case (state)
                ST_IDLE: if (i_play && !i_start) begin
                    if (play_ok) begin
                        step    <= 6'd0;
                        round_r <= i_round;
                        speed_r <= i_speed;
                    end else begin
                        err <= 1'b1;
                    end
                end
                ST_GEN: begin
                    gen_idx <= gen_idx + 5'd1;
                    if (gen_last) seq_valid <= 1'b1;
                end
                ST_GAP: if (phase_end && step != round_r - 6'd1) step <= step + 6'd1;
                default: ;
            endcase
            if (i_start) begin
                seq_len   <= eff_len;
                seq_valid <= 1'b0;
                gen_idx   <= 5'd0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (state == ST_GEN) mem[gen_idx] <= color_t'(lfsr[1:0]);
    end

    assign o_led       = (state == ST_ON) ? color_onehot(mem[step[4:0]]) : 4'b0000;
    assign o_busy      = (state != ST_IDLE);
    assign o_done      = (state == ST_DONE);
    assign o_err       = err;
    assign o_seq_len   = seq_len;
    assign o_seq_valid = seq_valid;
    assign o_rd_color  = rd_color;

endmodule
`default_nettype wire

// File: tb/tb_sequence_player.sv
`default_nettype none
// ============================================================================
// Module : tb_sequence_player
// Brief  : Directed/randomised bench for sequence_player with a reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sequence_player;

    localparam int TICK = 4;

    logic       i_clk = 1'b0, i_reset = 1'b1, i_start = 1'b0, i_play = 1'b0;
    logic [5:0] i_seq_len = 6'd0, i_round = 6'd0;
    logic [1:0] i_speed = 2'd0;
    logic [4:0] i_rd_idx = 5'd0;
    logic [1:0] o_rd_color;
    logic [3:0] o_led;
    logic [5:0] o_seq_len;
    logic       o_seq_valid, o_busy, o_done, o_err;

    sequence_player #(.MAX_LEN(32), .TICK_CYC(TICK)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_seq_len   (i_seq_len),
        .i_speed     (i_speed),
        .i_play      (i_play),
        .i_round     (i_round),
        .i_rd_idx    (i_rd_idx),
        .o_rd_color  (o_rd_color),
        .o_led       (o_led),
        .o_seq_len   (o_seq_len),
        .o_seq_valid (o_seq_valid),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0, errors = 0;
    int on_t  [4] = '{60, 40, 25, 15};
    int gap_t [4] = '{20, 15, 10, 5};

    // Reference LFSR: history of the value present during every clock cycle.
    logic [15:0] m_lfsr;
    logic [15:0] hist [$];
    logic [1:0]  exp_mem [32];

    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            m_lfsr = 16'hACE1;
        end else begin
            hist.push_back(m_lfsr);
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    function automatic logic [3:0] oh(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic readback(input int n);
        for (int j = 0; j < n; j++) begin
            i_rd_idx = 5'(j);
            tick(1);
            chk("rd_color", 32'(o_rd_color), 32'(exp_mem[j]));
        end
    endtask

    task automatic gen_and_check(input int len, input int eff);
        int base;
        i_seq_len = 6'(len);
        i_start   = 1'b1;
        tick(1);
        i_start = 1'b0;
        base = hist.size();
        for (int j = 0; j < eff; j++) begin
            chk("gen_busy", 32'({o_busy, o_seq_valid}), 32'b10);
            tick(1);
        end
        chk("gen_end", 32'({o_busy, o_seq_valid}), 32'b01);
        chk("seq_len", 32'(o_seq_len), 32'(eff));
        for (int j = 0; j < eff; j++) exp_mem[j] = hist[base + j][1:0];
        readback(eff);
    endtask

    task automatic err_check(input int round);
        i_round = 6'(round);
        i_play  = 1'b1;
        tick(1);
        i_play = 1'b0;
        chk("err_pulse", 32'({o_err, o_busy, o_led}), 32'b100000);
        tick(1);
        chk("err_clear", 32'({o_err, o_led}), 32'b00000);
    endtask

    task automatic play_check(input int speed, input int round);
        int per, total;
        per     = (on_t[speed] + gap_t[speed]) * TICK;
        total   = round * per;
        i_speed = 2'(speed);
        i_round = 6'(round);
        i_play  = 1'b1;
        tick(1);
        i_play = 1'b0;
        for (int k = 0; k < total; k++) begin
            logic [3:0] e;
            e = ((k % per) < on_t[speed] * TICK) ? oh(exp_mem[k / per]) : 4'b0000;
            chk("play_led", 32'({o_done, o_busy, o_led}), 32'({2'b01, e}));
            tick(1);
        end
        chk("play_done", 32'({o_done, o_busy, o_led}), 32'b110000);
        tick(1);
        chk("play_idle", 32'({o_done, o_busy}), 32'b00);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, s;
        tick(2);
        chk("rst_led",   32'(o_led), 32'd0);
        chk("rst_rd",    32'(o_rd_color), 32'd0);
        chk("rst_len",   32'(o_seq_len), 32'd0);
        chk("rst_flags", 32'({o_seq_valid, o_busy, o_done, o_err}), 32'd0);
        i_reset = 1'b0;
        tick($urandom_range(1, 20));

        err_check(1);
        gen_and_check(8, 8);
        play_check(3, 3);
        err_check(0);
        err_check(9);
        play_check(int'($urandom_range(0, 3)), int'($urandom_range(1, 8)));

        // Abort a playback with a new start while an LED is lit.
        i_speed = 2'd0; i_round = 6'd2; i_play = 1'b1;
        tick(1);
        i_play = 1'b0;
        tick(30);
        chk("abort_on", 32'(o_led), 32'(oh(exp_mem[0])));
        i_seq_len = 6'd5; i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        base = hist.size();
        for (int j = 0; j < 5; j++) begin
            chk("abort_gen", 32'({o_done, o_busy, o_seq_valid, o_led}), 32'b0100000);
            tick(1);
        end
        chk("abort_end", 32'({o_busy, o_seq_valid, o_seq_len}), {24'd0, 2'b01, 6'd5});
        for (int j = 0; j < 5; j++) exp_mem[j] = hist[base + j][1:0];
        readback(8);

        tick($urandom_range(1, 9));
        gen_and_check(0, 32);
        tick($urandom_range(1, 9));
        gen_and_check(40, 32);

        // Start and play together: start wins, no error.
        i_seq_len = 6'd6; i_start = 1'b1; i_play = 1'b1; i_round = 6'd1;
        tick(1);
        i_start = 1'b0; i_play = 1'b0;
        base = hist.size();
        chk("both_gen", 32'({o_busy, o_seq_valid, o_err, o_led}), 32'b1000000);
        tick(1);
        chk("both_noerr", 32'(o_err), 32'd0);
        tick(5);
        chk("both_end", 32'({o_busy, o_seq_valid, o_seq_len}), {24'd0, 2'b01, 6'd6});
        for (int j = 0; j < 6; j++) exp_mem[j] = hist[base + j][1:0];
        readback(6);

        // Reset asynchronously in the middle of a gap.
        s = int'($urandom_range(0, 3));
        i_speed = 2'(s); i_round = 6'd2; i_rd_idx = 5'd1; i_play = 1'b1;
        tick(1);
        i_play = 1'b0;
        tick(on_t[s] * TICK + 3);
        chk("gap_dark", 32'({o_busy, o_led}), 32'b10000);
        #2;
        i_reset = 1'b1;
        #1;
        chk("arst_led",   32'(o_led), 32'd0);
        chk("arst_rd",    32'(o_rd_color), 32'd0);
        chk("arst_len",   32'(o_seq_len), 32'd0);
        chk("arst_flags", 32'({o_seq_valid, o_busy, o_done, o_err}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
